// File: rtl/button_pkg.sv
// button_pkg: shared constants and types for the push-button conditioner.
//
// Contents:
//   BTN_DB_DEFAULT     - debounce stability window in clock cycles (5 ms @ 100 MHz)
//   BTN_HOLD_DEFAULT   - long-press threshold in clock cycles (1 s @ 100 MHz)
//   BTN_REPEAT_DEFAULT - auto-repeat period in clock cycles (250 ms @ 100 MHz)
//   btn_state_e        - per-channel state: IDLE, PRESSED, HELD
package button_pkg;

  localparam int BTN_DB_DEFAULT     = 500000;
  localparam int BTN_HOLD_DEFAULT   = 100000000;
  localparam int BTN_REPEAT_DEFAULT = 25000000;

  // level = (state != CH_IDLE), hold = (state == CH_HELD)
  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_PRESSED = 2'd1,
    CH_HELD    = 2'd2
  } btn_state_e;

endpackage

// File: rtl/button_channel.sv
// button_channel: one push-button channel.
//
// Two-flop synchroniser, candidate/counter debounce, IDLE/PRESSED/HELD state
// machine with registered rise/fall pulses and a long-press hold state.
// With BUTTON_REPEAT_EN defined an auto-repeat strobe is generated; without
// it rpt is tied low and no repeat counter exists.
//
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high
//   button - raw asynchronous button input
//   state  - current channel state (level/hold are decoded from it)
//   rise   - one-cycle pulse on an accepted press
//   fall   - one-cycle pulse on an accepted release
//   rpt    - one-cycle auto-repeat strobe (0 unless BUTTON_REPEAT_EN)
//
// Outputs are single-cycle strobes or levels with no valid/ready
// handshake: consumers sample them every cycle and cannot stall the channel.
module button_channel
  import button_pkg::*;
#(
  parameter int DB_CYCLES   = BTN_DB_DEFAULT,
  parameter int HOLD_CYCLES = BTN_HOLD_DEFAULT
`ifdef BUTTON_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES = BTN_REPEAT_DEFAULT
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  output btn_state_e state,
  output logic       rise,
  output logic       fall,
  output logic       rpt
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              cand_q, cand_d;
  logic [DB_W-1:0]   dcnt_q, dcnt_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  btn_state_e        state_q, state_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              level_cur;
  logic              accept;

  assign level_cur = (state_q != CH_IDLE);
  // A new level is taken only once the candidate has been stable long enough
  // and actually differs from the current level.
  assign accept    = (dcnt_q == DB_MAX) && (cand_q != level_cur);

  // Synchroniser and debounce counter
  always_comb begin
    s1_d   = button;
    s2_d   = s1_q;
    cand_d = cand_q;
    dcnt_d = dcnt_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      dcnt_d = '0;
    end else if (dcnt_q != DB_MAX) begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  // Hold counter runs only while the debounced level is high
  always_comb begin
    hcnt_d = '0;
    if (level_cur) begin
      hcnt_d = (hcnt_q == HOLD_MAX) ? hcnt_q : hcnt_q + 1'b1;
    end
  end

  // State machine: a release always wins over reaching the hold threshold,
  // so hold drops on the same edge as fall.
  always_comb begin
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (accept) begin
          state_d = CH_PRESSED;
          rise_d  = 1'b1;
        end
      end
      CH_PRESSED: begin
        if (accept) begin
          state_d = CH_IDLE;
          fall_d  = 1'b1;
        end else if (hcnt_q == HOLD_MAX) begin
          state_d = CH_HELD;
        end
      end
      CH_HELD: begin
        if (accept) begin
          state_d = CH_IDLE;
          fall_d  = 1'b1;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cand_q  <= 1'b0;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      state_q <= CH_IDLE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cand_q  <= cand_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign state = state_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef BUTTON_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rcnt_q, rcnt_d;
  logic             rpt_q, rpt_d;

  // rcnt counts cycles since the last strobe while HELD. It restarts on
  // entry to HELD and is cleared whenever the channel is not staying HELD,
  // so a release landing on a repeat boundary produces fall only.
  always_comb begin
    rcnt_d = '0;
    rpt_d  = rise_d | ((state_q == CH_PRESSED) && (state_d == CH_HELD));
    if ((state_q == CH_HELD) && !accept) begin
      if (rcnt_q == RPT_LAST) begin
        rpt_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rcnt_q <= '0;
      rpt_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rpt_q  <= rpt_d;
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_CH independent push-button conditioners.
//
// Each channel synchronises, debounces and edge-detects one raw button and
// flags long presses. Optional auto-repeat is compiled in with the macro
// BUTTON_REPEAT_EN; otherwise rpt is constant 0.
//
// Parameters: N_CH, DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES (all cycle counts >= 1)
// Ports:
//   clock  - 100 MHz system clock
//   reset  - synchronous, active-high
//   button - [N_CH] raw asynchronous buttons
//   level  - [N_CH] debounced state
//   rise   - [N_CH] one-cycle press pulse
//   fall   - [N_CH] one-cycle release pulse
//   hold   - [N_CH] high while a press has lasted >= HOLD_CYCLES
//   rpt    - [N_CH] one-cycle auto-repeat strobe
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH          = 5,
  parameter int DB_CYCLES     = BTN_DB_DEFAULT,
  parameter int HOLD_CYCLES   = BTN_HOLD_DEFAULT,
  parameter int REPEAT_CYCLES = BTN_REPEAT_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] hold,
  output logic [N_CH-1:0] rpt
);

  if (DB_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("button_conditioner: cycle-count parameters must be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_state_e ch_state;

    button_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES)
`ifdef BUTTON_REPEAT_EN
      ,
      .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
    ) u_channel (
      .clock  (clock),
      .reset  (reset),
      .button (button[i]),
      .state  (ch_state),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .rpt    (rpt[i])
    );

    assign level[i] = (ch_state != CH_IDLE);
    assign hold[i]  = (ch_state == CH_HELD);
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised N-channel push-button conditioner for the front-panel input path. Each channel synchronises a raw asynchronous button into the `clock` domain and debounces it to a stable level. It then derives one-cycle press and release pulses and a long-press hold flag. An optional auto-repeat strobe can be compiled in. Its outputs feed the run/stop, threshold-adjust and display-select control logic.

## Interface
- `N_CH`, default 5: number of independent button channels.
- `DB_CYCLES`, default 500000: consecutive stable cycles required to accept a new level; must be ≥1.
- `HOLD_CYCLES`, default 100000000: cycles a press must persist before `hold` asserts; must be ≥1.
- `REPEAT_CYCLES`, default 25000000: auto-repeat period while held; must be ≥1. Used only with `BUTTON_REPEAT_EN`.
- `clock`, input, 1: single system clock, 100 MHz.
- `reset`, input, 1: synchronous, active-high reset.
- `button`, input, N_CH: raw asynchronous button inputs.
- `level`, output, N_CH: debounced button state.
- `rise`, output, N_CH: one-cycle pulse when a press is accepted.
- `fall`, output, N_CH: one-cycle pulse when a release is accepted.
- `hold`, output, N_CH: high while the press has lasted ≥HOLD_CYCLES.
- `rpt`, output, N_CH: one-cycle auto-repeat strobe.

## Operation
- All channels are fully independent. No state is shared except `clock` and `reset`.
- Synchroniser: two flops per channel (`s1`, `s2`). `s2` is the sampled value.
- Debounce:
  - State per channel is a candidate bit `cand` and a counter `dcnt`.
  - If `s2 != cand`: `cand <= s2`, `dcnt <= 0`.
  - Otherwise `dcnt` increments, saturating at DB_CYCLES.
  - When `dcnt == DB_CYCLES` and `cand != level`: `level <= cand`.
  - A single-cycle glitch restarts the count. A glitch never reaches `level`.
- Edge pulses:
  - `rise` is asserted on the same edge that `level` goes 0→1.
  - `fall` is asserted on the same edge that `level` goes 1→0.
  - Both are high for exactly one cycle and are never high together.
- Hold:
  - `hcnt` clears whenever `level` is 0.
  - While `level` is 1, `hcnt` increments, saturating at HOLD_CYCLES.
  - `hold` is registered high when `hcnt` reaches HOLD_CYCLES.
  - `hold` drops on the same edge `level` falls, coincident with `fall`.
- Counter widths are `$clog2(max+1)` of their respective limits. No wrap-around is allowed; all counters saturate.
- Per-channel state machine: IDLE (`level`=0) → PRESSED (`level`=1, `hold`=0) → HELD (`hold`=1).
  - From either PRESSED or HELD, an accepted release returns the channel to IDLE.
  - IDLE → PRESSED fires `rise`.
  - Any release fires `fall`.

## Timing
- Reset clears every output, both synchroniser flops, `cand` and all counters on the next edge.
- Reset mid-bounce or mid-hold discards progress. No pulse is emitted on reset exit.
- After reset, `level`=0. A button already held at reset produces `rise` after the normal latency.
- Latency: with the input stable from edge E0, `level`/`rise`/`fall` update at E0+DB_CYCLES+3.
- `hold` asserts HOLD_CYCLES+1 cycles after the `rise` edge, measured as edges after the rise edge.

## Configuration
- Macro: `BUTTON_REPEAT_EN`.
- Defined: `rpt` pulses in three cases:
  - with `rise`;
  - on the edge `hold` asserts;
  - every REPEAT_CYCLES cycles thereafter while `hold` is high.
- Defined: the repeat counter clears on `fall` or reset. A release exactly on a repeat boundary emits `fall` only.
- Not defined: `rpt` is tied to 0 and no repeat counter is synthesised.

## Structure
- A shared package `button_pkg` holds the default constants: `BTN_DB_DEFAULT`, `BTN_HOLD_DEFAULT`, `BTN_REPEAT_DEFAULT`.
- The package also holds a channel-state enum for IDLE, PRESSED and HELD.
- One sub-module, `button_channel`, implements a single channel: synchroniser, debounce, edge, hold and repeat logic.
- The top level instantiates `button_channel` N_CH times in a generate loop.

## Test plan
All scenarios use N_CH=2, DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Clean press: `button[0]` 0→1 held from E0 → `level[0]`=1 and `rise[0]` one cycle at E0+7; `fall` stays 0.
- Bounce: toggle `button[0]` 1,0,1,0 on alternating cycles, then hold 1 → no `rise` until 7 cycles after the final transition; exactly one `rise` overall.
- Long press: hold `button[1]`=1 for 40 cycles → `hold[1]` goes high 11 cycles after `rise[1]`; release → `fall[1]` and `hold[1]` low on the same edge.
- Independent channels: ch0 pressed at E0, ch1 pressed at E0+2 → `rise[0]` at E0+7, `rise[1]` at E0+9; no cross-effects.
- Reset mid-operation: press, then assert `reset` for 1 cycle at `dcnt`=2 → all outputs 0; `rise` occurs 7 cycles after reset release with the button still high.
- Repeat (`BUTTON_REPEAT_EN`): long press → `rpt` at `rise`, at `hold` assertion, then every 3 cycles; release stops `rpt` immediately. Without the macro, `rpt` stays 0 throughout.
